// File: rtl/lcd_ctrl.sv
// HD44780 4-bit-bus LCD controller: autonomous power-up/init sequence, then
// streams host command/data bytes from a small FIFO to the panel pins.
module lcd_ctrl #(
    parameter int CLOCK_RATE = 1000,
    parameter int EN_CYCLES  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter bit TWO_LINE   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       init_done,
    output logic       busy,
    output logic       en,
    output logic       rs,
    output logic [3:0] data
);
    localparam int TICK_DIV = CLOCK_RATE / 1000;
    localparam int CW = $clog2(40*TICK_DIV + 4*EN_CYCLES + 10*TICK_DIV + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] PWR_END = CW'(40*TICK_DIV - 1);
    localparam logic [CW-1:0] EN1     = CW'(EN_CYCLES);
    localparam logic [CW-1:0] EN2     = CW'(2*EN_CYCLES);
    localparam logic [CW-1:0] EN3     = CW'(3*EN_CYCLES);
    localparam logic [CW-1:0] EN4     = CW'(4*EN_CYCLES);
    localparam logic [CW-1:0] EN2M1   = CW'(2*EN_CYCLES - 1);
    localparam logic [CW-1:0] TICK1   = CW'(TICK_DIV);
    localparam logic [CW-1:0] TICK2   = CW'(2*TICK_DIV);
    localparam logic [CW-1:0] TICK5   = CW'(5*TICK_DIV);
    localparam logic [PW:0]   FULL_COUNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [7:0]    FUNC_SET = TWO_LINE ? 8'h28 : 8'h20;

    typedef enum logic [2:0] {
        POWERUP, INIT_NIB, INIT_BYTE, IDLE, SEND_HI, SEND_LO, WAIT
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    step, step_n;
    logic          en_n, rs_n, done_n;
    logic [3:0]    data_n;
    logic [7:0]    cur_byte, byte_n;
    logic          cur_rs, brs_n;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr, count_n;
    logic [8:0]    head;
    logic          push, pop, empty;

    logic [7:0]    init_byte;
    logic [CW-1:0] nib_wait, init_wait, send_wait;
    logic [CW-1:0] nib_end, ibyte_end, wait_end;

    // Clear/home instructions need the long post-byte wait.
    function automatic logic [CW-1:0] post_wait(input logic r, input logic [7:0] b);
        return (!r && (b == 8'h01 || b == 8'h02 || b == 8'h03)) ? TICK2 : TICK1;
    endfunction

    assign empty   = (wr_ptr == rd_ptr);
    assign head    = mem[rd_ptr[PW-1:0]];
    assign push    = cmd_valid && cmd_ready;
    assign count_n = (wr_ptr - rd_ptr) + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    assign busy    = (state != IDLE) || !empty;

    always_comb begin
        unique case (step)
            2'd0:    init_byte = FUNC_SET;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
        unique case (step)
            2'd0, 2'd1: nib_wait = TICK5;
            2'd2:       nib_wait = TICK1;
            default:    nib_wait = '0;
        endcase
        init_wait = post_wait(1'b0, init_byte);
        send_wait = post_wait(cur_rs, cur_byte);
        nib_end   = EN2 + nib_wait - CW'(1);
        ibyte_end = EN4 + init_wait - CW'(1);
        wait_end  = send_wait - CW'(1);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        step_n  = step;
        en_n    = en;
        rs_n    = rs;
        data_n  = data;
        done_n  = init_done;
        byte_n  = cur_byte;
        brs_n   = cur_rs;
        pop     = 1'b0;
        unique case (state)
            POWERUP: begin
                if (cnt == PWR_END) begin
                    state_n = INIT_NIB;
                    cnt_n   = '0;
                end
            end
            INIT_NIB: begin
                if (cnt == '0) begin
                    en_n   = 1'b1;
                    rs_n   = 1'b0;
                    data_n = (step == 2'd3) ? 4'h2 : 4'h3;
                end else if (cnt == EN1) begin
                    en_n = 1'b0;
                end
                if (cnt == nib_end) begin
                    cnt_n  = '0;
                    step_n = step + 2'd1;
                    if (step == 2'd3) state_n = INIT_BYTE;
                end
            end
            INIT_BYTE: begin
                if (cnt == '0) begin
                    en_n   = 1'b1;
                    rs_n   = 1'b0;
                    data_n = init_byte[7:4];
                end else if (cnt == EN1 || cnt == EN3) begin
                    en_n = 1'b0;
                end else if (cnt == EN2) begin
                    en_n   = 1'b1;
                    data_n = init_byte[3:0];
                end
                if (cnt == ibyte_end) begin
                    cnt_n  = '0;
                    step_n = step + 2'd1;
                    if (step == 2'd3) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            IDLE: begin
                cnt_n = '0;
                if (init_done && !empty) begin
                    pop     = 1'b1;
                    byte_n  = head[7:0];
                    brs_n   = head[8];
                    state_n = SEND_HI;
                end
            end
            SEND_HI, SEND_LO: begin
                if (cnt == '0) begin
                    en_n   = 1'b1;
                    rs_n   = cur_rs;
                    data_n = (state == SEND_HI) ? cur_byte[7:4] : cur_byte[3:0];
                end else if (cnt == EN1) begin
                    en_n = 1'b0;
                end
                if (cnt == EN2M1) begin
                    cnt_n   = '0;
                    state_n = (state == SEND_HI) ? SEND_LO : WAIT;
                end
            end
            WAIT: begin
                if (cnt == wait_end) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = POWERUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= POWERUP;
            cnt       <= '0;
            step      <= '0;
            en        <= 1'b0;
            rs        <= 1'b0;
            data      <= '0;
            init_done <= 1'b0;
            cur_byte  <= '0;
            cur_rs    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            step      <= step_n;
            en        <= en_n;
            rs        <= rs_n;
            data      <= data_n;
            init_done <= done_n;
            cur_byte  <= byte_n;
            cur_rs    <= brs_n;
        end
    end

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
            cmd_ready <= (count_n != FULL_COUNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= {cmd_rs, cmd_data};
    end
endmodule
